cpu_ea_unit: RTL and testbench
==============================

// Module: cpu_ea_unit
// PURPOSE
//  Parametrised effective-address sequencer for the 6502-class core. Sits between the opcode decoder and the bus.
//  Given an addressing mode, the PC and X/Y, it fetches operand/pointer bytes over a bus port with wait states.
//  It returns the effective address (EA), the updated PC and a page-cross flag.
//  Adds a relocatable zero page, JMP-indirect bug emulation and page-cross penalty cycles.
// PARAMETERS
//  ZP_PAGE       8'h00  high byte of the zero page; all ZP/pointer accesses go to {ZP_PAGE, lo8}
//  PAGE_PENALTY  1      1: ABX/ABY/NDY reads that cross a page take +1 cycle
//  JMP_IND_BUG   1      1: IND hi byte is read from {ptr[15:8], ptr[7:0]+1} (8-bit wrap); 0: from ptr+1
// PORTS
//  clock       in   1   system clock
//  resetn      in   1   asynchronous active-low reset
//  locked      in   1   global enable; 0 freezes all state and outputs
//  start       in   1   request; accepted only in IDLE with locked=1
//  mode        in   4   addressing mode (shared constants)
//  is_write    in   1   store/RMW access: indexed modes always take the penalty cycle
//  pc_in       in   16  address of the first operand byte
//  x_in, y_in  in   8   index registers, sampled at start
//  bus_addr    out  16  read address
//  bus_rd      out  1   read request
//  bus_ready   in   1   read completes (i_data valid) in a cycle where bus_rd=1 and bus_ready=1
//  i_data      in   8   read data
//  ea          out  16  effective address
//  pc_next     out  16  pc_in + operand byte count
//  page_cross  out  1   ABX/ABY/NDY: carry out of the low byte; REL: target page != (pc_in+1) page
//  ea_valid    out  1   result valid; held in DONE until a cycle with locked=1
//  busy        out  1   state != IDLE
// BEHAVIOUR
//  - Reset (async): state=IDLE; all outputs 0. A mid-operation reset drops bus_rd at once; no partial result.
//  - All registers advance only when locked=1.
//  - A read state advances only on bus_ready=1. Each bus_ready=0 cycle adds 1 cycle; bus_addr stays stable.
//  - start while busy is ignored. Mode codes 12..15 behave as IMP. Inputs are latched at accept.
//  - States: IDLE, OPL, OPH, IDX, PTL, PTH, FIX, DONE. DONE -> IDLE after one locked cycle.
//  - Per mode: read sequence -> ea; pc_next; latency (accept to ea_valid, no wait states).
//    IMP: none -> 0; pc; 1
//    IMM: none -> pc; pc+1; 1
//    ZP: [pc]=a -> {ZP_PAGE,a}; pc+1; 2
//    ZPX/ZPY: [pc]=a, IDX -> {ZP_PAGE,a+X/Y mod 256}; pc+1; 3
//    ABS: [pc],[pc+1] -> {hi,lo}; pc+2; 3
//    ABX/ABY: as ABS, then EA = {hi,lo}+X/Y (16-bit wrap); pc+2; 3
//      +1 FIX if (PAGE_PENALTY & page_cross) | is_write
//    NDX: [pc]=z, IDX, p=z+X mod 256, [{ZP_PAGE,p}]=lo, [{ZP_PAGE,p+1 mod 256}]=hi -> {hi,lo}; pc+1; 5
//    NDY: [pc]=z, [{ZP_PAGE,z}]=lo, [{ZP_PAGE,z+1 mod 256}]=hi -> {hi,lo}+Y; pc+1; 4
//      +1 FIX under the same penalty rule as ABX/ABY
//    IND: [pc],[pc+1]=ptr, [ptr]=lo, [ptr+1 or bug addr]=hi -> {hi,lo}; pc+2; 5
//    REL: [pc]=o -> pc_in+1+sext(o) (16-bit wrap); pc+1; 2; no penalty cycle
//  - page_cross is 0 for all modes not listed in PORTS.
//  - ea, pc_next and page_cross are registered and hold until the next accept.
// STRUCTURE
//  - Shared header cpu_modes.vh: mode codes IMP=0, IMM=1, ZP=2, ZPX=3, ZPY=4, ABS=5, ABX=6, ABY=7,
//    NDX=8, NDY=9, IND=10, REL=11. The same header also holds the FSM state constants.
//  - Sub-module cpu_ea_add: combinational {base16 + idx8} -> sum16, page_cross. Reused by ABX/ABY/NDY/REL.
// TESTING
//  1. ABX, pc_in=0x8000, [0x8000]=F8, [0x8001]=12, X=10, read, PAGE_PENALTY=1
//     -> ea=1308, page_cross=1, ea_valid 4 cycles after accept, pc_next=8002.
//  2. NDX, [pc]=FE, X=01, ZP_PAGE=00
//     -> reads 00FF then 0000 (wrap); ea={[0000],[00FF]}. ZP_PAGE=20 -> reads 20FF then 2000.
//  3. IND, ptr=02FF -> JMP_IND_BUG=1 reads hi from 0200; JMP_IND_BUG=0 reads hi from 0300.
//  4. REL, pc_in=80F0: o=20 -> ea=8111, page_cross=1; o=80 -> ea=8071, page_cross=0; latency 2.
//  5. ZP with bus_ready=0 for 3 cycles -> bus_addr held; ea_valid at cycle 5. locked=0 in DONE -> ea_valid held.
//  6. resetn low during NDY PTH -> bus_rd=0, busy=0, ea_valid=0 immediately.
//     After release, ZP start -> correct result in 2 cycles.

Source files
------------

// File: rtl/cpu_ea_unit_pkg.sv
// rtl/cpu_ea_unit_pkg.sv - addressing-mode codes, FSM states and mode helpers for the EA sequencer
package cpu_ea_unit_pkg;

    localparam logic [3:0] MODE_IMP = 4'd0;
    localparam logic [3:0] MODE_IMM = 4'd1;
    localparam logic [3:0] MODE_ZP  = 4'd2;
    localparam logic [3:0] MODE_ZPX = 4'd3;
    localparam logic [3:0] MODE_ZPY = 4'd4;
    localparam logic [3:0] MODE_ABS = 4'd5;
    localparam logic [3:0] MODE_ABX = 4'd6;
    localparam logic [3:0] MODE_ABY = 4'd7;
    localparam logic [3:0] MODE_NDX = 4'd8;
    localparam logic [3:0] MODE_NDY = 4'd9;
    localparam logic [3:0] MODE_IND = 4'd10;
    localparam logic [3:0] MODE_REL = 4'd11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPL,
        ST_OPH,
        ST_IDX,
        ST_PTL,
        ST_PTH,
        ST_FIX,
        ST_DONE
    } ea_state_e;

    // Bytes following the opcode that belong to the instruction.
    function automatic logic [1:0] operand_bytes(input logic [3:0] mode);
        logic [1:0] n;
        case (mode)
            MODE_ABS, MODE_ABX, MODE_ABY, MODE_IND: n = 2'd2;
            MODE_IMP:                               n = 2'd0;
            default:                                n = 2'd1;
        endcase
        return n;
    endfunction

    function automatic logic uses_y(input logic [3:0] mode);
        return (mode == MODE_ZPY) || (mode == MODE_ABY) || (mode == MODE_NDY);
    endfunction

endpackage

// File: rtl/cpu_ea_add.sv
// rtl/cpu_ea_add.sv - 16-bit base plus 8-bit (optionally signed) index with page-cross detect
module cpu_ea_add (
    input  logic [15:0] base,
    input  logic [7:0]  idx,
    input  logic        idx_signed,
    output logic [15:0] sum,
    output logic        page_cross
);

    logic [15:0] idx_ext;

    assign idx_ext    = {{8{idx_signed & idx[7]}}, idx};
    assign sum        = base + idx_ext;
    assign page_cross = (sum[15:8] != base[15:8]);

endmodule

// File: rtl/cpu_ea_unit.sv
// rtl/cpu_ea_unit.sv - effective-address sequencer: fetches operand/pointer bytes and returns EA, next PC, page cross
module cpu_ea_unit
    import cpu_ea_unit_pkg::*;
#(
    parameter logic [7:0] ZP_PAGE      = 8'h00,
    parameter bit         PAGE_PENALTY = 1'b1,
    parameter bit         JMP_IND_BUG  = 1'b1
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        locked,
    input  logic        start,
    input  logic [3:0]  mode,
    input  logic        is_write,
    input  logic [15:0] pc_in,
    input  logic [7:0]  x_in,
    input  logic [7:0]  y_in,
    output logic [15:0] bus_addr,
    output logic        bus_rd,
    input  logic        bus_ready,
    input  logic [7:0]  i_data,
    output logic [15:0] ea,
    output logic [15:0] pc_next,
    output logic        page_cross,
    output logic        ea_valid,
    output logic        busy
);

    ea_state_e   state_q, state_d;
    logic [3:0]  mode_q, mode_d;
    logic        wr_q, wr_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] ptr_q, ptr_d;
    logic [15:0] ea_q, ea_d;
    logic [15:0] pcn_q, pcn_d;
    logic        pg_q, pg_d;

    logic [3:0]  mode_n;
    logic [7:0]  zp_idx;
    logic        fix_needed;
    logic [15:0] ptr_hi;

    logic        add_rel;
    logic [15:0] add_base;
    logic [7:0]  add_idx;
    logic [15:0] add_sum;
    logic        add_pc;

    // One adder serves REL (signed offset on pc+1, in OPL) and the indexed
    // absolute/indirect modes ({fetched hi, lo} + X/Y, in OPH or PTH).
    assign add_rel  = (state_q == ST_OPL);
    assign add_base = add_rel ? (pc_q + 16'd1) : {i_data, lo_q};
    assign add_idx  = add_rel ? i_data : idx_q;

    cpu_ea_add u_add (
        .base       (add_base),
        .idx        (add_idx),
        .idx_signed (add_rel),
        .sum        (add_sum),
        .page_cross (add_pc)
    );

    always_comb begin
        bus_rd   = 1'b0;
        bus_addr = 16'h0000;
        ptr_hi   = (mode_q == MODE_IND && !JMP_IND_BUG) ? (ptr_q + 16'd1)
                                                         : {ptr_q[15:8], ptr_q[7:0] + 8'd1};
        case (state_q)
            ST_OPL: begin
                bus_rd   = 1'b1;
                bus_addr = pc_q;
            end
            ST_OPH: begin
                bus_rd   = 1'b1;
                bus_addr = pc_q + 16'd1;
            end
            ST_PTL: begin
                bus_rd   = 1'b1;
                bus_addr = ptr_q;
            end
            ST_PTH: begin
                bus_rd   = 1'b1;
                bus_addr = ptr_hi;
            end
            default: begin
                bus_rd   = 1'b0;
                bus_addr = 16'h0000;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        wr_d       = wr_q;
        pc_d       = pc_q;
        idx_d      = idx_q;
        lo_d       = lo_q;
        ptr_d      = ptr_q;
        ea_d       = ea_q;
        pcn_d      = pcn_q;
        pg_d       = pg_q;
        mode_n     = (mode > MODE_REL) ? MODE_IMP : mode;
        zp_idx     = lo_q + idx_q;
        fix_needed = (PAGE_PENALTY && add_pc) || wr_q;

        if (locked) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_d  = mode_n;
                        wr_d    = is_write;
                        pc_d    = pc_in;
                        idx_d   = uses_y(mode_n) ? y_in : x_in;
                        pcn_d   = pc_in + {14'd0, operand_bytes(mode_n)};
                        pg_d    = 1'b0;
                        ea_d    = (mode_n == MODE_IMM) ? pc_in : 16'h0000;
                        state_d = (mode_n == MODE_IMP || mode_n == MODE_IMM) ? ST_DONE : ST_OPL;
                    end
                end
                ST_OPL: begin
                    if (bus_ready) begin
                        lo_d = i_data;
                        case (mode_q)
                            MODE_ZP: begin
                                ea_d    = {ZP_PAGE, i_data};
                                state_d = ST_DONE;
                            end
                            MODE_ZPX, MODE_ZPY, MODE_NDX: state_d = ST_IDX;
                            MODE_NDY: begin
                                ptr_d   = {ZP_PAGE, i_data};
                                state_d = ST_PTL;
                            end
                            MODE_REL: begin
                                ea_d    = add_sum;
                                pg_d    = add_pc;
                                state_d = ST_DONE;
                            end
                            default: state_d = ST_OPH;
                        endcase
                    end
                end
                ST_OPH: begin
                    if (bus_ready) begin
                        case (mode_q)
                            MODE_ABS: begin
                                ea_d    = {i_data, lo_q};
                                state_d = ST_DONE;
                            end
                            MODE_ABX, MODE_ABY: begin
                                ea_d    = add_sum;
                                pg_d    = add_pc;
                                state_d = fix_needed ? ST_FIX : ST_DONE;
                            end
                            default: begin
                                ptr_d   = {i_data, lo_q};
                                state_d = ST_PTL;
                            end
                        endcase
                    end
                end
                ST_IDX: begin
                    if (mode_q == MODE_NDX) begin
                        ptr_d   = {ZP_PAGE, zp_idx};
                        state_d = ST_PTL;
                    end else begin
                        ea_d    = {ZP_PAGE, zp_idx};
                        state_d = ST_DONE;
                    end
                end
                ST_PTL: begin
                    if (bus_ready) begin
                        lo_d    = i_data;
                        state_d = ST_PTH;
                    end
                end
                ST_PTH: begin
                    if (bus_ready) begin
                        if (mode_q == MODE_NDY) begin
                            ea_d    = add_sum;
                            pg_d    = add_pc;
                            state_d = fix_needed ? ST_FIX : ST_DONE;
                        end else begin
                            ea_d    = {i_data, lo_q};
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_FIX:  state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_IMP;
            wr_q    <= 1'b0;
            pc_q    <= 16'h0000;
            idx_q   <= 8'h00;
            lo_q    <= 8'h00;
            ptr_q   <= 16'h0000;
            ea_q    <= 16'h0000;
            pcn_q   <= 16'h0000;
            pg_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            wr_q    <= wr_d;
            pc_q    <= pc_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
            ptr_q   <= ptr_d;
            ea_q    <= ea_d;
            pcn_q   <= pcn_d;
            pg_q    <= pg_d;
        end
    end

    assign ea         = ea_q;
    assign pc_next    = pcn_q;
    assign page_cross = pg_q;
    assign ea_valid   = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cpu_ea_unit.sv
// tb/tb_cpu_ea_unit.sv - two-instance self-checking bench for cpu_ea_unit against a memory/arithmetic model
module tb_cpu_ea_unit;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        resetn, locked, start, is_write;
    logic [3:0]  mode;
    logic [15:0] pc_in;
    logic [7:0]  x_in, y_in;

    logic [15:0] bus_addr [2];
    logic        bus_rd    [2];
    logic        bus_ready [2];
    logic [7:0]  i_data    [2];
    logic [15:0] ea        [2];
    logic [15:0] pc_next   [2];
    logic        page_cross[2];
    logic        ea_valid  [2];
    logic        busy      [2];

    cpu_ea_unit u_dut_a (
        .clock(clock), .resetn(resetn), .locked(locked), .start(start), .mode(mode),
        .is_write(is_write), .pc_in(pc_in), .x_in(x_in), .y_in(y_in),
        .bus_addr(bus_addr[0]), .bus_rd(bus_rd[0]), .bus_ready(bus_ready[0]), .i_data(i_data[0]),
        .ea(ea[0]), .pc_next(pc_next[0]), .page_cross(page_cross[0]),
        .ea_valid(ea_valid[0]), .busy(busy[0])
    );

    cpu_ea_unit #(.ZP_PAGE(8'h20), .PAGE_PENALTY(1'b0), .JMP_IND_BUG(1'b0)) u_dut_b (
        .clock(clock), .resetn(resetn), .locked(locked), .start(start), .mode(mode),
        .is_write(is_write), .pc_in(pc_in), .x_in(x_in), .y_in(y_in),
        .bus_addr(bus_addr[1]), .bus_rd(bus_rd[1]), .bus_ready(bus_ready[1]), .i_data(i_data[1]),
        .ea(ea[1]), .pc_next(pc_next[1]), .page_cross(page_cross[1]),
        .ea_valid(ea_valid[1]), .busy(busy[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [7:0]  mem [65536];
    logic [15:0] log_rd [2][$];
    logic [15:0] exp_rd [$];
    int          wait_cnt [2];
    int          forced_waits [2];
    bit          rand_ready;
    bit          was_wait [2];
    logic [15:0] held_addr [2];

    logic [15:0] res_ea [2];
    logic [15:0] res_pcn [2];
    logic        res_pg [2];
    int          res_cyc [2];
    logic [15:0] exp_ea [2];

    // Bus slave: responds from mem, waits either scripted or random
    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (was_wait[i] && bus_rd[i])
                check($sformatf("addr_hold%0d", i), bus_addr[i], held_addr[i]);
            if (bus_rd[i] && forced_waits[i] > 0) begin
                bus_ready[i] = 1'b0;
                forced_waits[i]--;
            end else begin
                bus_ready[i] = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            i_data[i] = mem[bus_addr[i]];
        end
    end

    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            was_wait[i]  = resetn && locked && bus_rd[i] && !bus_ready[i];
            held_addr[i] = bus_addr[i];
            if (resetn && locked && bus_rd[i]) begin
                if (bus_ready[i]) log_rd[i].push_back(bus_addr[i]);
                else              wait_cnt[i]++;
            end
        end
    end

    function automatic logic [7:0] rdm(input logic [15:0] ad);
        exp_rd.push_back(ad);
        return mem[ad];
    endfunction

    task automatic model(input int i, input logic [3:0] m, input logic [15:0] pc,
                         input logic [7:0] x, input logic [7:0] y, input bit wr,
                         output logic [15:0] e_ea, output logic [15:0] e_pcn,
                         output bit e_pg, output int e_lat);
        logic [7:0]  zp, a, lo, hi, idx;
        logic [15:0] base, p, hp;
        bit          pen, bug;
        zp  = (i == 0) ? 8'h00 : 8'h20;
        pen = (i == 0);
        bug = (i == 0);
        idx = (m == 4 || m == 7 || m == 9) ? y : x;
        exp_rd.delete();
        e_pg  = 1'b0;
        e_ea  = 16'h0000;
        e_pcn = pc;
        e_lat = 1;
        case (m)
            4'd1: begin e_ea = pc; e_pcn = pc + 16'd1; end
            4'd2: begin a = rdm(pc); e_ea = {zp, a}; e_pcn = pc + 16'd1; e_lat = 2; end
            4'd3, 4'd4: begin
                a = rdm(pc); a = a + idx;
                e_ea = {zp, a}; e_pcn = pc + 16'd1; e_lat = 3;
            end
            4'd5, 4'd6, 4'd7: begin
                lo = rdm(pc); hi = rdm(pc + 16'd1); base = {hi, lo};
                e_pcn = pc + 16'd2;
                if (m == 4'd5) begin
                    e_ea = base; e_lat = 3;
                end else begin
                    e_ea  = base + {8'h00, idx};
                    e_pg  = (e_ea[15:8] != base[15:8]);
                    e_lat = ((pen && e_pg) || wr) ? 4 : 3;
                end
            end
            4'd8: begin
                a = rdm(pc); a = a + x;
                lo = rdm({zp, a}); a = a + 8'd1; hi = rdm({zp, a});
                e_ea = {hi, lo}; e_pcn = pc + 16'd1; e_lat = 5;
            end
            4'd9: begin
                a = rdm(pc);
                lo = rdm({zp, a}); a = a + 8'd1; hi = rdm({zp, a});
                base  = {hi, lo};
                e_ea  = base + {8'h00, y};
                e_pg  = (e_ea[15:8] != base[15:8]);
                e_pcn = pc + 16'd1;
                e_lat = ((pen && e_pg) || wr) ? 5 : 4;
            end
            4'd10: begin
                lo = rdm(pc); hi = rdm(pc + 16'd1); p = {hi, lo};
                lo = rdm(p);
                a  = p[7:0] + 8'd1;
                hp = bug ? {p[15:8], a} : p + 16'd1;
                hi = rdm(hp);
                e_ea = {hi, lo}; e_pcn = pc + 16'd2; e_lat = 5;
            end
            4'd11: begin
                a = rdm(pc); p = pc + 16'd1;
                e_ea = p + {{8{a[7]}}, a};
                e_pg = (e_ea[15:8] != p[15:8]);
                e_pcn = pc + 16'd1; e_lat = 2;
            end
            default: ;
        endcase
    endtask

    task automatic run_txn(input logic [3:0] m, input logic [15:0] pc, input logic [7:0] x,
                           input logic [7:0] y, input bit wr, input int hold);
        logic [15:0] e_ea, e_pcn;
        bit          e_pg;
        int          e_lat;
        bit          done [2];
        for (int i = 0; i < 2; i++) begin
            log_rd[i].delete();
            wait_cnt[i] = 0;
            done[i]     = 1'b0;
            res_cyc[i]  = 0;
        end
        mode = m; pc_in = pc; x_in = x; y_in = y; is_write = wr; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!done[i] && ea_valid[i]) begin
                    done[i]    = 1'b1;
                    res_cyc[i] = c;
                    res_ea[i]  = ea[i];
                    res_pcn[i] = pc_next[i];
                    res_pg[i]  = page_cross[i];
                end
            end
            if (done[0] && done[1]) break;
            @(posedge clock); #1;
        end
        for (int i = 0; i < 2; i++) begin
            if (!done[i]) begin
                check($sformatf("timeout%0d_m%0d", i, m), 32'd0, 32'd1);
            end else begin
                model(i, m, pc, x, y, wr, e_ea, e_pcn, e_pg, e_lat);
                exp_ea[i] = e_ea;
                check($sformatf("ea%0d_m%0d", i, m), res_ea[i], e_ea);
                check($sformatf("pcn%0d_m%0d", i, m), res_pcn[i], e_pcn);
                check($sformatf("pg%0d_m%0d", i, m), res_pg[i], e_pg);
                check($sformatf("lat%0d_m%0d", i, m), res_cyc[i], e_lat + wait_cnt[i]);
                check($sformatf("nrd%0d_m%0d", i, m), log_rd[i].size(), exp_rd.size());
                for (int k = 0; k < exp_rd.size() && k < log_rd[i].size(); k++)
                    check($sformatf("rd%0d_%0d_m%0d", i, k, m), log_rd[i][k], exp_rd[k]);
            end
        end
        if (hold > 0) begin
            locked = 1'b0;
            repeat (hold) begin
                @(posedge clock); #1;
                check("hold_valid", ea_valid[0], 1'b1);
                check("hold_ea", ea[0], exp_ea[0]);
            end
            locked = 1'b1;
        end
        @(posedge clock); #1;
        check("idle_a", busy[0], 1'b0);
        check("idle_b", busy[1], 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        resetn = 1'b0; locked = 1'b1; start = 1'b0; is_write = 1'b0;
        mode = 4'd0; pc_in = 16'h0; x_in = 8'h0; y_in = 8'h0;
        rand_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            forced_waits[i] = 0; was_wait[i] = 1'b0; bus_ready[i] = 1'b1; i_data[i] = 8'h00;
        end
        repeat (3) @(posedge clock);
        #1;
        check("rst_ea", ea[0], 16'h0);
        check("rst_pcn", pc_next[0], 16'h0);
        check("rst_pg", page_cross[0], 1'b0);
        check("rst_valid", ea_valid[0], 1'b0);
        check("rst_busy", busy[0], 1'b0);
        check("rst_rd", bus_rd[0], 1'b0);
        check("rst_addr", bus_addr[0], 16'h0);
        resetn = 1'b1;
        @(posedge clock); #1;

        mem[16'h8000] = 8'hF8; mem[16'h8001] = 8'h12;
        run_txn(4'd6, 16'h8000, 8'h10, 8'h00, 1'b0, 0);
        check("t1_ea", res_ea[0], 16'h1308);
        check("t1_pg", res_pg[0], 1'b1);
        check("t1_lat", res_cyc[0], 4);
        check("t1_pcn", res_pcn[0], 16'h8002);
        check("t1_lat_nopen", res_cyc[1], 3);

        mem[16'h4000] = 8'hFE;
        mem[16'h00FF] = 8'h34; mem[16'h0000] = 8'h12;
        mem[16'h20FF] = 8'h78; mem[16'h2000] = 8'h56;
        run_txn(4'd8, 16'h4000, 8'h01, 8'h00, 1'b0, 0);
        check("t2_rd1", log_rd[0][1], 16'h00FF);
        check("t2_rd2", log_rd[0][2], 16'h0000);
        check("t2_ea", res_ea[0], 16'h1234);
        check("t2_zp_rd1", log_rd[1][1], 16'h20FF);
        check("t2_zp_rd2", log_rd[1][2], 16'h2000);
        check("t2_zp_ea", res_ea[1], 16'h5678);

        mem[16'h5000] = 8'hFF; mem[16'h5001] = 8'h02;
        mem[16'h02FF] = 8'hCD; mem[16'h0200] = 8'hAB; mem[16'h0300] = 8'hEF;
        run_txn(4'd10, 16'h5000, 8'h00, 8'h00, 1'b0, 0);
        check("t3_bug_rd", log_rd[0][3], 16'h0200);
        check("t3_bug_ea", res_ea[0], 16'hABCD);
        check("t3_nobug_rd", log_rd[1][3], 16'h0300);
        check("t3_nobug_ea", res_ea[1], 16'hEFCD);

        mem[16'h80F0] = 8'h20;
        run_txn(4'd11, 16'h80F0, 8'h00, 8'h00, 1'b0, 0);
        check("t4a_ea", res_ea[0], 16'h8111);
        check("t4a_pg", res_pg[0], 1'b1);
        check("t4a_lat", res_cyc[0], 2);
        mem[16'h80F0] = 8'h80;
        run_txn(4'd11, 16'h80F0, 8'h00, 8'h00, 1'b0, 0);
        check("t4b_ea", res_ea[0], 16'h8071);
        check("t4b_pg", res_pg[0], 1'b0);

        mem[16'h6000] = 8'h42;
        forced_waits[0] = 3; forced_waits[1] = 3;
        run_txn(4'd2, 16'h6000, 8'h00, 8'h00, 1'b0, 3);
        check("t5_lat", res_cyc[0], 5);
        check("t5_ea", res_ea[0], 16'h0042);
        check("t5_zp_ea", res_ea[1], 16'h2042);

        rand_ready = 1'b1;
        for (int n = 0; n < 200; n++) begin
            run_txn(4'($urandom_range(0, 15)), 16'($urandom), 8'($urandom), 8'($urandom),
                    ($urandom_range(0, 3) == 0), 0);
        end
        rand_ready = 1'b0;

        mode = 4'd9; pc_in = 16'h7000; x_in = 8'h00; y_in = 8'h33; is_write = 1'b0;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("t6_in_pth", bus_rd[0], 1'b1);
        resetn = 1'b0;
        #1;
        check("t6_rd", bus_rd[0], 1'b0);
        check("t6_busy", busy[0], 1'b0);
        check("t6_valid", ea_valid[0], 1'b0);
        check("t6_ea", ea[0], 16'h0);
        @(posedge clock); #1;
        resetn = 1'b1;
        @(posedge clock); #1;
        mem[16'h7100] = 8'h9A;
        run_txn(4'd2, 16'h7100, 8'h00, 8'h00, 1'b0, 0);
        check("t6_zp_lat", res_cyc[0], 2);
        check("t6_zp_ea", res_ea[0], 16'h009A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
